// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: parametrised pipeline-stage register with valid/ready
// handshake and a 2-entry skid buffer. in_ready is registered, so no
// combinational ready path reaches the upstream stage.
// Interrupt redirect (req) injects HANDLER_PC. Flush turns the held beat into a bubble.
// Optional feature macro: PIPE_STAGE_STALL_CNT_EN (backpressure cycle counter).
module pipe_stage_skid #(
  parameter int              PC_W       = 32,
  parameter int              INSTR_W    = 32,
  parameter int              EXC_W      = 5,
  parameter int              SIDE_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_3000,
  parameter logic [PC_W-1:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [EXC_W-1:0]   in_exc,
  input  logic               in_bd,
  input  logic [SIDE_W-1:0]  in_side,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [EXC_W-1:0]   out_exc,
  output logic               out_bd,
  output logic [SIDE_W-1:0]  out_side,
  output logic [31:0]        stall_cnt
);

  // Beat layout: {pc, instr, exc, bd, side}; payload is everything except pc.
  localparam int PAY_W  = INSTR_W + EXC_W + 1 + SIDE_W;
  localparam int BEAT_W = PC_W + PAY_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // A bubble keeps the PC (so EPC still has a value) and zeroes the payload,
  // which makes out_instr a nop while the stage is empty.
  function automatic logic [BEAT_W-1:0] make_bubble(input logic [BEAT_W-1:0] beat);
    make_bubble = {beat[BEAT_W-1 -: PC_W], {PAY_W{1'b0}}};
  endfunction

  state_t              state_r;
  state_t              state_next_s;
  logic [BEAT_W-1:0]   main_r;
  logic [BEAT_W-1:0]   main_next_s;
  logic [BEAT_W-1:0]   skid_r;
  logic [BEAT_W-1:0]   skid_next_s;
  logic [BEAT_W-1:0]   in_beat_s;
  logic                in_ready_r;
  logic                out_valid_r;
  logic                in_fire_s;
  logic                out_fire_s;

  assign in_beat_s  = {in_pc, in_instr, in_exc, in_bd, in_side};
  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready;

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_pc     = main_r[BEAT_W-1 -: PC_W];
  assign out_instr  = main_r[PAY_W-1 -: INSTR_W];
  assign out_exc    = main_r[EXC_W+SIDE_W -: EXC_W];
  assign out_bd     = main_r[SIDE_W];
  assign out_side   = main_r[SIDE_W-1:0];

  // Next-state and next-storage selection: req > flush > handshake.
  always_comb begin
    state_next_s = state_r;
    main_next_s  = main_r;
    skid_next_s  = skid_r;
    if (req) begin
      // Redirect: handler entry becomes the only held beat; any incoming beat is dropped.
      main_next_s  = {HANDLER_PC, {PAY_W{1'b0}}};
      state_next_s = ST_ONE;
    end else if (flush) begin
      // Kill everything held; skid contents become don't-care once invalid.
      main_next_s  = make_bubble(main_r);
      state_next_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            main_next_s  = in_beat_s;
            state_next_s = ST_ONE;
          end else begin
            state_next_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_next_s  = in_beat_s;
            state_next_s = ST_ONE;
          end else if (in_fire_s) begin
            skid_next_s  = in_beat_s;
            state_next_s = ST_FULL;
          end else if (out_fire_s) begin
            main_next_s  = make_bubble(main_r);
            state_next_s = ST_EMPTY;
          end else begin
            state_next_s = ST_ONE;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire_s) begin
            main_next_s  = skid_r;
            state_next_s = ST_ONE;
          end else begin
            state_next_s = ST_FULL;
          end
        end
        default: begin
          main_next_s  = make_bubble(main_r);
          state_next_s = ST_EMPTY;
        end
      endcase
    end
  end

  // State, storage and the registered handshake flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= ST_EMPTY;
      main_r      <= {RESET_PC, {PAY_W{1'b0}}};
      skid_r      <= {BEAT_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      main_r      <= main_next_s;
      skid_r      <= skid_next_s;
      in_ready_r  <= (state_next_s != ST_FULL);
      out_valid_r <= (state_next_s != ST_EMPTY);
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

  logic [31:0] stall_cnt_r;

  // Saturating count of cycles where a valid beat is held back by the consumer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_r <= 32'd0;
    end else if (out_valid_r && !out_ready && (stall_cnt_r != STALL_MAX)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline-stage register, the successor to the fixed IF/ID latch; usable between any two core stages (IF/ID, ID/EX, ...).
- Carries PC, instruction, exception code, delay-slot flag and a generic sideband.
- Replaces the global stall enable with a valid/ready handshake, backed by a 2-entry skid buffer so `in_ready` is registered (no combinational ready path upstream).
- Retains interrupt redirect (injects the handler entry) and flush (bubble insertion).

Parameters:
- PC_W, 32, PC width
- INSTR_W, 32, instruction width
- EXC_W, 5, exception-code width
- SIDE_W, 8, generic sideband payload width (>=1)
- RESET_PC, 32'h0000_3000, `out_pc` value after reset
- HANDLER_PC, 32'h0000_4180, PC injected on `req`

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `reset_n`  in  1  synchronous active-low reset
- `req`  in  1  interrupt/exception redirect request
- `flush`  in  1  kill all held entries (insert bubble)
- `in_valid`  in  1  upstream beat valid
- `in_ready`  out  1  stage can accept a beat; registered
- `in_pc`  in  PC_W  upstream PC
- `in_instr`  in  INSTR_W  upstream instruction
- `in_exc`  in  EXC_W  upstream exception code
- `in_bd`  in  1  upstream delay-slot flag
- `in_side`  in  SIDE_W  upstream sideband
- `out_valid`  out  1  downstream beat valid
- `out_ready`  in  1  downstream accepts beat
- `out_pc`  out  PC_W  held PC
- `out_instr`  out  INSTR_W  held instruction (0 = nop when empty)
- `out_exc`  out  EXC_W  held exception code
- `out_bd`  out  1  held delay-slot flag
- `out_side`  out  SIDE_W  held sideband
- `stall_cnt`  out  32  backpressure cycle counter (see Optional Feature)

Behaviour:
- Storage and states:
  - Main register drives `out_*`; a skid register holds one extra beat.
  - States: EMPTY (main invalid), ONE (main valid), FULL (main + skid valid).
  - `in_ready` = (state != FULL), registered.
  - `out_valid` = (state != EMPTY).
- Fire conditions: in_fire = `in_valid` & `in_ready`; out_fire = `out_valid` & `out_ready`.
- Priority per cycle: reset > `req` > `flush` > handshake.
- Reset (`reset_n`=0 at edge):
  - State EMPTY; `out_pc`=RESET_PC; `out_instr`, `out_exc`, `out_bd`, `out_side`, skid contents = 0.
  - `in_ready`=1 from the next cycle.
  - `stall_cnt`=0.
  - Reset overrides any beat in flight.
- `req`=1:
  - Main <= {HANDLER_PC, instr 0, exc 0, bd 0, side 0}; skid invalidated; state ONE.
  - Any same-cycle in_fire beat is discarded; the upstream is redirected concurrently at core level.
- `flush`=1 (no `req`):
  - State EMPTY; skid invalidated; `out_instr`, `out_exc`, `out_bd`, `out_side` <= 0.
  - `out_pc` holds its previous value so a bubble still reports a PC for EPC.
  - Same-cycle in_fire beat is discarded.
- Handshake transitions:
  - EMPTY: in_fire -> ONE, main <= in. Otherwise stay; `out_pc` holds last value, other outputs already zero.
  - ONE:
    - in_fire & out_fire -> ONE, main <= in.
    - in_fire only -> FULL, skid <= in.
    - out_fire only -> EMPTY, `out_instr`/`out_exc`/`out_bd`/`out_side` <= 0, `out_pc` holds.
    - Neither -> hold.
  - FULL:
    - out_fire -> ONE, main <= skid, skid invalidated.
    - No out_fire -> hold.
    - `in_ready`=0, so no in_fire is possible.
- Latency and throughput:
  - 1 cycle from in_fire into EMPTY, or into ONE with simultaneous out_fire, to `out_valid`.
  - Full throughput of 1 beat/cycle when `out_ready` is held 1.
  - Order is strictly FIFO; no beat is duplicated or lost except by `req`/`flush`/reset.
- Boundaries:
  - `in_valid` while FULL: ignored; upstream must hold its beat.
  - `out_ready` while EMPTY: no effect.
  - Simultaneous `req` and `flush`: `req` wins.

Optional Feature:
- Macro: `PIPE_STAGE_STALL_CNT_EN`.
- Defined:
  - `stall_cnt` increments by 1 each cycle with `out_valid`=1 & `out_ready`=0.
  - Saturates at 32'hFFFF_FFFF; cleared only by reset.
  - Unaffected by `req`/`flush`.
- Undefined: `stall_cnt` tied to 0 and no counter logic is synthesised.

Test Plan:
- Reset then idle: `reset_n`=0 for 2 cycles -> `out_valid`=0, `out_pc`=32'h3000, `out_instr`=0, `in_ready`=1.
- Streaming: PCs 3000, 3004, 3008, 300C with `out_ready`=1 -> each appears one cycle after in_fire, 4 consecutive out_fires, `in_ready` stays 1.
- Backpressure: `out_ready`=0, send 3000, 3004, 3008 ->
  - stage holds 3000 (main) and 3004 (skid); `in_ready`=0; 3008 held upstream.
  - Release `out_ready` -> output order 3000, 3004, 3008.
  - With macro defined, `stall_cnt` equals the number of stalled cycles.
- Flush: stage FULL holding 3010/3014, assert `flush` -> next cycle `out_valid`=0, `out_instr`=0, `out_pc`=3010, `in_ready`=1.
- Interrupt: stage FULL, assert `req` together with `flush` and `in_valid` -> next cycle `out_valid`=1, `out_pc`=32'h4180, `out_instr`=0, `out_exc`=0, `out_bd`=0, skid empty.
- Reset mid-operation: stage FULL with `out_ready`=0, pulse `reset_n`=0 for 1 cycle -> EMPTY, `out_pc`=32'h3000, `stall_cnt`=0.
